// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS core memories
package mips_pkg;
    localparam logic [31:0] NOP_INSN      = 32'h0000_0000;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;
    typedef enum logic {S_LOAD, S_RUN} imem_state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM with write enable and registered read
module imem_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;
    logic [DW-1:0] mem [DEPTH];
    // one access per cycle: write when we, otherwise register the read word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: boot-loadable instruction memory with registered fetch port
module imem_loadable
    import mips_pkg::*;
#(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter bit          BOOT_LOAD = 1'b1,
    parameter logic [31:0] NOP_WORD  = NOP_INSN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_valid,
    input  logic [31:0]          load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic [ADDR_BITS:0]   load_count,
    input  logic                 reload,
    output logic                 run,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_addr,
    input  logic                 stall,
    output logic [31:0]          instruction,
    output logic                 inst_valid,
    output logic                 addr_fault
);
    imem_state_t state, state_nx;
    logic [ADDR_BITS-1:0] wptr, idx, ram_addr;
    logic [31:0] off, rdata;
    logic hs, fault, ram_en, ram_we, valid_q, fault_q;

    assign off   = fetch_addr - BASE_ADDR;
    assign idx   = off[ADDR_BITS+1:2];
    assign fault = (off[1:0] != 2'b00) | (off[31:ADDR_BITS+2] != '0);

    // next state, handshake and the single RAM port steering
    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        run        = 1'b0;
        hs         = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = idx;
        if (state == S_LOAD) begin
            load_ready = 1'b1;
            hs         = load_valid;
            ram_en     = load_valid;
            ram_we     = load_valid;
            ram_addr   = wptr;
            if (load_valid && (load_last || &wptr)) state_nx = S_RUN;
        end else begin
            run = 1'b1;
            if (reload) state_nx = S_LOAD;
            else if (!stall && fetch_req && !fault) ram_en = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= BOOT_LOAD ? S_LOAD : S_RUN;
        else state <= state_nx;
    end

    // write pointer and saturating load counter, cleared by reload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            load_count <= '0;
        end else if (run && reload) begin
            wptr       <= '0;
            load_count <= '0;
        end else if (hs) begin
            wptr <= wptr + 1'b1;
            if (!load_count[ADDR_BITS]) load_count <= load_count + 1'b1;
        end
    end

    // fetch qualifiers track the RAM read register; stall freezes both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (run && reload) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (run && !stall) begin
            valid_q <= fetch_req;
            fault_q <= fetch_req & fault;
        end
    end

    assign inst_valid  = valid_q;
    assign addr_fault  = fault_q;
    assign instruction = (valid_q && !fault_q) ? rdata : NOP_WORD;

    imem_ram #(.AW(ADDR_BITS), .DW(32)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed, table-driven check of the loadable instruction memory
module tb_imem_loadable;
    logic clk = 1'b0, reset_n = 1'b0;
    logic load_valid = 1'b0, load_last = 1'b0, load_ready;
    logic [31:0] load_data = '0;
    logic [8:0] load_count;
    logic reload = 1'b0, run, fetch_req = 1'b0, stall = 1'b0;
    logic [31:0] fetch_addr = '0, instruction;
    logic inst_valid, addr_fault;
    int checks = 0, failures = 0;

    typedef struct {
        logic        req;
        logic        stl;
        logic [31:0] addr;
        logic [31:0] ei;
        logic        ev;
        logic        ef;
    } vec_t;

    always #5 clk = ~clk;

    imem_loadable dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count),
        .reload(reload), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .instruction(instruction), .inst_valid(inst_valid), .addr_fault(addr_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [31:0] ei, input logic ev, input logic ef);
        chk({nm, "_instr"}, instruction, ei);
        chk({nm, "_valid"}, 32'(inst_valid), 32'(ev));
        chk({nm, "_fault"}, 32'(addr_fault), 32'(ef));
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1'b1; fetch_addr = a; stall = 1'b0;
        tick();
    endtask

    logic [31:0] prog [4];
    vec_t vecs [18];

    initial begin
        prog[0] = 32'h24080000; prog[1] = 32'h8d100000;
        prog[2] = 32'h00102021; prog[3] = 32'h21050004;
        vecs[0]  = '{1, 0, 32'h00400008, 32'h00102021, 1, 0};
        vecs[1]  = '{1, 0, 32'h00400000, 32'h24080000, 1, 0};
        vecs[2]  = '{1, 0, 32'h0040000C, 32'h21050004, 1, 0};
        vecs[3]  = '{1, 0, 32'h00400006, 32'h00000000, 1, 1};
        vecs[4]  = '{1, 0, 32'h003FFFFC, 32'h00000000, 1, 1};
        vecs[5]  = '{1, 0, 32'h00400400, 32'h00000000, 1, 1};
        vecs[6]  = '{0, 0, 32'h00400000, 32'h00000000, 0, 0};
        vecs[7]  = '{1, 0, 32'h00400004, 32'h8d100000, 1, 0};
        vecs[8]  = '{1, 1, 32'h0040000C, 32'h8d100000, 1, 0};
        vecs[9]  = '{1, 1, 32'h0040000C, 32'h8d100000, 1, 0};
        vecs[10] = '{1, 1, 32'h0040000C, 32'h8d100000, 1, 0};
        vecs[11] = '{1, 0, 32'h0040000C, 32'h21050004, 1, 0};
        vecs[12] = '{1, 0, 32'h00400001, 32'h00000000, 1, 1};
        vecs[13] = '{1, 1, 32'h00400000, 32'h00000000, 1, 1};
        vecs[14] = '{0, 0, 32'h00400000, 32'h00000000, 0, 0};
        vecs[15] = '{1, 1, 32'h00400004, 32'h00000000, 0, 0};
        vecs[16] = '{1, 0, 32'h00400004, 32'h8d100000, 1, 0};
        vecs[17] = '{1, 0, 32'h00400002, 32'h00000000, 1, 1};

        // reset state
        #12;
        chk("rst_ready", 32'(load_ready), 1);
        chk("rst_run", 32'(run), 0);
        chk_out("rst", 32'h0, 0, 0);
        chk("rst_count", 32'(load_count), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // boot-load four words
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
            tick();
            if (i == 2) begin
                chk("load3_run", 32'(run), 0);
                chk("load3_count", 32'(load_count), 3);
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("load4_run", 32'(run), 1);
        chk("load4_ready", 32'(load_ready), 0);
        chk("load4_count", 32'(load_count), 4);
        chk_out("run_idle", 32'h0, 0, 0);

        // fetch, fault, bubble and stall vectors
        foreach (vecs[i]) begin
            fetch_req = vecs[i].req; stall = vecs[i].stl; fetch_addr = vecs[i].addr;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ei, vecs[i].ev, vecs[i].ef);
        end
        stall = 1'b0;

        // reload has priority over a simultaneous fetch
        fetch(32'h00400000);
        reload = 1'b1; fetch_addr = 32'h00400004;
        tick();
        reload = 1'b0; fetch_req = 1'b0;
        chk("reload_run", 32'(run), 0);
        chk("reload_ready", 32'(load_ready), 1);
        chk("reload_count", 32'(load_count), 0);
        chk_out("reload", 32'h0, 0, 0);

        // full-depth stream without load_last: automatic exit after word 255
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1; load_data = 32'hA000_0000 | 32'(i);
            tick();
            if (i == 254) begin
                chk("full255_run", 32'(run), 0);
                chk("full255_count", 32'(load_count), 255);
            end
        end
        chk("full_run", 32'(run), 1);
        chk("full_ready", 32'(load_ready), 0);
        chk("full_count", 32'(load_count), 256);
        load_data = 32'hDEAD_BEEF;
        tick();
        load_valid = 1'b0;
        chk("full_hold_count", 32'(load_count), 256);
        fetch(32'h004003FC);
        chk_out("full_w255", 32'hA00000FF, 1, 0);
        fetch(32'h00400000);
        chk_out("full_w0", 32'hA0000000, 1, 0);
        fetch(32'h00400008);
        chk_out("full_w2", 32'hA0000002, 1, 0);

        // asynchronous reset during a reload cycle
        reload = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(load_ready), 1);
        chk("arst_run", 32'(run), 0);
        chk("arst_count", 32'(load_count), 0);
        chk_out("arst", 32'h0, 0, 0);
        reload = 1'b0; fetch_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // reload one word after an idle cycle; rest of memory retained
        tick();
        chk("idle_count", 32'(load_count), 0);
        load_valid = 1'b1; load_last = 1'b1; load_data = 32'h1234_5678;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("one_run", 32'(run), 1);
        chk("one_count", 32'(load_count), 1);
        fetch(32'h00400000);
        chk_out("one_w0", 32'h12345678, 1, 0);
        fetch(32'h00400004);
        chk_out("keep_w1", 32'hA0000001, 1, 0);
        fetch_req = 1'b0;
        tick();
        chk_out("end_bubble", 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised synchronous instruction memory for the pipelined MIPS core. Replaces the hard-coded combinational ROM.
- Holds DEPTH 32-bit words and is programmed at run time through a streaming boot-load port, so no re-synthesis is needed per program.
- Serves IF-stage fetches with one-cycle registered latency, stall hold, base-relative addressing and fault reporting for misaligned or out-of-range PCs.

Parameters:
- ADDR_BITS, 8, word-index width; DEPTH = 2**ADDR_BITS words.
- BASE_ADDR, 32'h0040_0000, byte address of word 0 (text segment base).
- BOOT_LOAD, 1, 1 = enter LOAD after reset; 0 = enter RUN directly.
- NOP_WORD, 32'h0000_0000, word returned on fault or bubble.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load word present.
- load_data  in  32  instruction word to store.
- load_last  in  1  qualifies load_valid; marks the final word.
- load_ready  out  1  memory accepts load words (state LOAD).
- load_count  out  ADDR_BITS+1  words written in the current load session.
- reload  in  1  pulse in RUN: return to LOAD, restart at word 0.
- run  out  1  state RUN; core may fetch.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  PC, byte address.
- stall  in  1  hold current fetch output.
- instruction  out  32  fetched word, registered.
- inst_valid  out  1  instruction is valid.
- addr_fault  out  1  the fetch now on the outputs was misaligned or out of range.

Behaviour:
- Reset (async, reset_n=0):
  - state = LOAD if BOOT_LOAD else RUN.
  - wptr = 0; load_count = 0.
  - instruction = NOP_WORD; inst_valid = 0; addr_fault = 0.
  - Memory array is not reset; contents are retained.
  - Reset mid-load aborts the session; words already written stay.
- FSM has two states, LOAD and RUN. load_ready = (state==LOAD); run = (state==RUN).
- LOAD:
  - Handshake fires when load_valid & load_ready: mem[wptr] <= load_data; wptr++; load_count++.
  - Exit to RUN on the cycle after a handshake with load_last=1, or with wptr==DEPTH-1 (array full).
  - No write beyond DEPTH-1 can occur.
  - fetch_req is ignored; inst_valid = 0; instruction = NOP_WORD.
- RUN, per rising edge:
  - reload=1: next state LOAD, wptr = 0, load_count = 0, inst_valid = 0, addr_fault = 0. reload has priority over fetch and stall.
  - Else if stall=1: instruction, inst_valid and addr_fault hold. fetch_req and fetch_addr are ignored.
  - Else if fetch_req=1:
    - off = fetch_addr - BASE_ADDR (32-bit, wraps); idx = off[ADDR_BITS+1:2].
    - fault = (off[1:0]!=0) | (off[31:ADDR_BITS+2]!=0).
    - instruction = fault ? NOP_WORD : mem[idx]; inst_valid = 1; addr_fault = fault.
  - Else (bubble): inst_valid = 0; addr_fault = 0; instruction = NOP_WORD.
- Latency: the word for a fetch issued in cycle N is on the outputs in cycle N+1.
- load_count saturates at DEPTH. It holds through RUN and clears on reload.
- Memory is inferable as single-port block RAM: write only in LOAD, read only in RUN. No read/write collision.

Decomposition:
- Shared package mips_pkg: NOP_WORD, default BASE_ADDR, imem_state_t enum {S_LOAD, S_RUN}.
- One natural sub-module, imem_ram: DEPTH x 32 synchronous single-port RAM with write enable and registered read.
- Load FSM, address translation, fault detection and stall hold logic live in imem_loadable.

Test Plan:
- Reset with BOOT_LOAD=1 -> load_ready=1, run=0, inst_valid=0, instruction=0, load_count=0.
- Load 4 words (24080000, 8d100000, 00102021, 21050004), last with load_last=1 -> load_count=4, run=1 one cycle after the final handshake. Fetch 0x00400008 -> next cycle instruction=00102021, inst_valid=1, addr_fault=0.
- Fetch 0x00400004, then assert stall for 3 cycles while fetch_addr changes to 0x0040000C -> instruction holds 8d100000 for all 3 cycles; after release, 21050004 appears.
- Fetch 0x00400006 (misaligned), 0x003FFFFC (below base), 0x00400400 (index 256 with ADDR_BITS=8) -> each gives instruction=0, inst_valid=1, addr_fault=1.
- Stream 256 words with load_last never asserted -> automatic RUN after word 255, load_count=256, load_ready=0.
- In RUN assert reload together with fetch_req -> next cycle run=0, inst_valid=0, load_count=0. Deassert reset_n mid-reload -> outputs return to reset values immediately (asynchronously).
